// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - XLEN_DEFAULT : datapath width (only 32 is supported)
//   - F3_*         : funct3 encodings for loads and stores
//   - state_e      : bus-access FSM states
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3 encodings shared by loads and stores (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the memory stage.
// Ports:
//   funct3_i    : access size / signedness
//   addr_lo_i   : byte offset within the word
//   is_load_i   : access is a load
//   is_store_i  : access is a store
//   wdata_i     : raw store data (low bits significant)
//   rdata_i     : word returned by the data bus
//   be_o        : byte enables for the addressed lanes
//   wdata_o     : store data replicated across all lanes
//   misalign_o  : access is misaligned or uses an illegal funct3
//   load_data_o : selected lane, sign- or zero-extended
// -----------------------------------------------------------------------------
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [XLEN-1:0] shifted;

  // Decode size from funct3. Shifting the read word right by the byte offset
  // puts the addressed byte/half in the low lane, so extraction is uniform.
  // Stores replicate data into every lane; the byte enables pick the lane.
  always_comb begin
    shifted     = rdata_i >> {addr_lo_i, 3'b000};
    be_o        = 4'b0000;
    wdata_o     = wdata_i;
    misalign_o  = 1'b0;
    load_data_o = rdata_i;

    case (funct3_i)
      F3_B, F3_BU: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{wdata_i[7:0]}};
        load_data_o = (funct3_i == F3_BU) ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_o     = {2{wdata_i[15:0]}};
        misalign_o  = addr_lo_i[0];
        load_data_o = (funct3_i == F3_HU) ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        be_o       = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase

    // Unsigned variants have no store form, and a simultaneous load+store
    // has no meaningful bus encoding.
    if (is_store_i && funct3_i[2]) begin
      misalign_o = 1'b1;
    end
    if (is_load_i && is_store_i) begin
      misalign_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage sitting after execute. Non-memory results pass
// straight through to writeback in one cycle; loads and stores issue a single
// outstanding request on the data bus and stall execute until it is acked or
// times out.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-low reset
//   rd_*_i, mem_*_i,
//   opfunc3_i             : registered outputs of execute
//   stall_o               : hold execute (combinational)
//   dbus_*_o / dbus_*_i   : data bus request, payload, ack and read data
//   rd_*_o                : registered result toward writeback
//   misalign_o, bus_err_o : one-cycle exception pulses
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_we_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      opfunc3_i,
  output logic            stall_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_ack_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic [4:0]      req_rd_addr_q, req_rd_addr_d;
  logic            req_rd_we_q, req_rd_we_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_we_q, rd_we_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic            al_misalign;
  logic [XLEN-1:0] al_load;
  logic            mem_op;
  logic            timeout_hit;

  // While BUSY the upstream inputs are stale, so the lane logic is fed from
  // the captured request; that lets one instance serve both issue and
  // load-data extraction.
  assign al_f3 = (state_q == BUSY) ? f3_q : opfunc3_i;
  assign al_lo = (state_q == BUSY) ? lo_q : mem_addr_i[1:0];

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .funct3_i    (al_f3),
    .addr_lo_i   (al_lo),
    .is_load_i   (mem_re_i),
    .is_store_i  (mem_we_i),
    .wdata_i     (rd_data_i),
    .rdata_i     (dbus_rdata_i),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .misalign_o  (al_misalign),
    .load_data_o (al_load)
  );

  assign mem_op      = mem_re_i | mem_we_i;
  // The counter holds the number of ack-less BUSY cycles already seen, so
  // reaching TO_LAST without ack means this is the final allowed cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // Next-state and output logic. In IDLE we either pass an ALU result through,
  // flag an illegal access, or issue a bus request. In BUSY the ack has
  // priority over the timeout, so an ack on the last allowed cycle still
  // completes normally.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    f3_d          = f3_q;
    lo_d          = lo_q;
    req_rd_addr_d = req_rd_addr_q;
    req_rd_we_d   = req_rd_we_q;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    rd_we_d       = rd_we_q;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;
    stall_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rd_addr_d = rd_addr_i;
          rd_data_d = rd_data_i;
          rd_we_d   = rd_we_i;
        end else if (al_misalign) begin
          misalign_d = 1'b1;
          rd_we_d    = 1'b0;
        end else begin
          stall_o       = 1'b1;
          req_d         = 1'b1;
          we_d          = mem_we_i;
          addr_d        = {mem_addr_i[XLEN-1:2], 2'b00};
          be_d          = al_be;
          wdata_d       = al_wdata;
          f3_d          = opfunc3_i;
          lo_d          = mem_addr_i[1:0];
          req_rd_addr_d = rd_addr_i;
          req_rd_we_d   = rd_we_i;
          rd_we_d       = 1'b0;
          cnt_d         = '0;
          state_d       = BUSY;
        end
      end

      BUSY: begin
        rd_we_d = 1'b0;
        if (dbus_ack_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            rd_addr_d = req_rd_addr_q;
            rd_data_d = al_load;
            rd_we_d   = req_rd_we_q && (req_rd_addr_q != 5'd0);
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          req_d     = 1'b0;
          state_d   = IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, which also abandons
  // any in-flight request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      req_rd_addr_q <= '0;
      req_rd_we_q   <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      rd_we_q       <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      f3_q          <= f3_d;
      lo_q          <= lo_d;
      req_rd_addr_q <= req_rd_addr_d;
      req_rd_we_q   <= req_rd_we_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      rd_we_q       <= rd_we_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign rd_we_o      = rd_we_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed testbench for mem_stage, built with a 4-cycle bus timeout.
// Each scenario task drives its stimulus and compares outputs against
// hand-computed values one cycle at a time.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_we_i;
  logic [31:0] mem_addr_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [2:0]  opfunc3_i;
  logic        stall_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;
  logic        misalign_o;
  logic        bus_err_o;

  int errors = 0;
  int checks = 0;

  mem_stage #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_i    (rd_data_i),
    .rd_we_i      (rd_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_re_i     (mem_re_i),
    .mem_we_i     (mem_we_i),
    .opfunc3_i    (opfunc3_i),
    .stall_o      (stall_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .rd_we_o      (rd_we_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  // Free-running 10-unit clock.
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge, where registered outputs are
  // stable and new inputs may be driven.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Return upstream inputs to an idle, non-writing ALU op.
  task automatic drive_idle();
    rd_addr_i  = 5'd0;
    rd_data_i  = 32'h0;
    rd_we_i    = 1'b0;
    mem_addr_i = 32'h0;
    mem_re_i   = 1'b0;
    mem_we_i   = 1'b0;
    opfunc3_i  = 3'b000;
  endtask

  // Hold reset for two cycles with busy-looking inputs and expect all
  // registered outputs at zero.
  task automatic test_reset();
    logic [110:0] outs;
    rst_i      = 1'b0;
    drive_idle();
    rd_we_i    = 1'b1;
    rd_addr_i  = 5'd3;
    rd_data_i  = 32'hDEAD_BEEF;
    dbus_ack_i = 1'b0;
    tick();
    tick();
    outs = {dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
            rd_addr_o, rd_data_o, rd_we_o, misalign_o, bus_err_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stall: got %b expected 0", stall_o);
    end
    rst_i = 1'b1;
    drive_idle();
    tick();
  endtask

  // ALU result flows through in one cycle without stalling.
  task automatic test_passthrough();
    rd_addr_i = 5'd5;
    rd_data_i = 32'h0000_1234;
    rd_we_i   = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_stall: got %b expected 0", stall_o);
    end
    tick();
    checks++;
    if ({rd_addr_o, rd_data_o, rd_we_o} !== {5'd5, 32'h0000_1234, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pass_result: got %h/%h/%b expected 05/00001234/1",
               rd_addr_o, rd_data_o, rd_we_o);
    end
    drive_idle();
    tick();
  endtask

  // Issue a load, wait 'waits' ack-less BUSY cycles, then ack with 'rdata'.
  // Execute must see stall for the issue cycle plus every waiting cycle.
  task automatic test_load(input string name, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rdata, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_data,
                           input logic exp_we);
    int stalls;
    stalls     = 0;
    rd_addr_i  = rd;
    rd_data_i  = 32'h1111_2222;
    rd_we_i    = 1'b1;
    mem_addr_i = addr;
    mem_re_i   = 1'b1;
    opfunc3_i  = f3;
    #1;
    if (stall_o === 1'b1) stalls++;
    tick();
    checks++;
    if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, rd_we_o} !==
        {1'b1, 1'b0, {addr[31:2], 2'b00}, exp_be, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s_request: got req=%b we=%b addr=%h be=%b rdwe=%b expected req=1 we=0 addr=%h be=%b rdwe=0",
               name, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, rd_we_o,
               {addr[31:2], 2'b00}, exp_be);
    end
    for (int b = 0; b <= waits; b++) begin
      if (b == waits) begin
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = rdata;
      end
      #1;
      if (stall_o === 1'b1) stalls++;
      tick();
      dbus_ack_i = 1'b0;
    end
    drive_idle();
    checks++;
    if (stalls !== waits + 1) begin
      errors++;
      $display("[TB] FAIL %s_stall_cycles: got %0d expected %0d", name, stalls, waits + 1);
    end
    checks++;
    if ({dbus_req_o, rd_addr_o, rd_data_o, rd_we_o} !==
        {1'b0, (exp_we ? rd : rd_addr_o), exp_data, exp_we}) begin
      errors++;
      $display("[TB] FAIL %s_result: got req=%b rd=%h data=%h we=%b expected req=0 rd=%h data=%h we=%b",
               name, dbus_req_o, rd_addr_o, rd_data_o, rd_we_o, rd, exp_data, exp_we);
    end
    tick();
  endtask

  // SH with immediate ack: lane-replicated data, upper-half enables, no
  // writeback, two-cycle latency (stall only in the issue cycle).
  task automatic test_store_half();
    rd_addr_i  = 5'd3;
    rd_data_i  = 32'h0000_BEEF;
    rd_we_i    = 1'b1;
    mem_addr_i = 32'h0000_0022;
    mem_we_i   = 1'b1;
    opfunc3_i  = 3'b001;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sh_issue_stall: got %b expected 1", stall_o);
    end
    tick();
    checks++;
    if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o} !==
        {1'b1, 1'b1, 32'h0000_0020, 4'b1100, 32'hBEEF_BEEF}) begin
      errors++;
      $display("[TB] FAIL sh_request: got req=%b we=%b addr=%h be=%b wdata=%h expected 1/1/00000020/1100/beefbeef",
               dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o);
    end
    dbus_ack_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sh_ack_stall: got %b expected 0", stall_o);
    end
    tick();
    dbus_ack_i = 1'b0;
    drive_idle();
    checks++;
    if ({dbus_req_o, rd_we_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL sh_done: got req=%b rdwe=%b expected 0/0", dbus_req_o, rd_we_o);
    end
    tick();
  endtask

  // Misaligned and illegal accesses: one-cycle misalign pulse, no request,
  // no writeback, no stall.
  task automatic test_misalign();
    logic [31:0] addrs [4];
    logic [2:0]  f3s   [4];
    logic [1:0]  rws   [4];
    addrs = '{32'h0000_0041, 32'h0000_0013, 32'h0000_0000, 32'h0000_0004};
    f3s   = '{3'b010,        3'b001,        3'b100,        3'b010};
    rws   = '{2'b10,         2'b01,         2'b01,         2'b11};
    for (int i = 0; i < 4; i++) begin
      rd_addr_i  = 5'd9;
      rd_data_i  = 32'hCAFE_0000;
      rd_we_i    = 1'b1;
      mem_addr_i = addrs[i];
      {mem_re_i, mem_we_i} = rws[i];
      opfunc3_i  = f3s[i];
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL misalign%0d_stall: got %b expected 0", i, stall_o);
      end
      tick();
      drive_idle();
      checks++;
      if ({misalign_o, dbus_req_o, rd_we_o} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL misalign%0d_pulse: got mis=%b req=%b rdwe=%b expected 1/0/0",
                 i, misalign_o, dbus_req_o, rd_we_o);
      end
      tick();
      checks++;
      if (misalign_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL misalign%0d_clear: got %b expected 0", i, misalign_o);
      end
    end
  endtask

  // Never ack: four BUSY cycles, stall released on the fourth, then a bus
  // error pulse and the next ALU op passes through.
  task automatic test_timeout();
    rd_addr_i  = 5'd4;
    rd_we_i    = 1'b1;
    mem_addr_i = 32'h0000_0080;
    mem_re_i   = 1'b1;
    opfunc3_i  = 3'b010;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({stall_o, bus_err_o, dbus_req_o} !== {(i < 4), 1'b0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL timeout_busy%0d: got stall=%b err=%b req=%b expected %b/0/1",
                 i, stall_o, bus_err_o, dbus_req_o, (i < 4));
      end
      tick();
    end
    drive_idle();
    rd_addr_i = 5'd6;
    rd_data_i = 32'h0000_0055;
    rd_we_i   = 1'b1;
    checks++;
    if ({bus_err_o, dbus_req_o, rd_we_o} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL timeout_err: got err=%b req=%b rdwe=%b expected 1/0/0",
               bus_err_o, dbus_req_o, rd_we_o);
    end
    tick();
    checks++;
    if ({bus_err_o, rd_addr_o, rd_data_o, rd_we_o} !== {1'b0, 5'd6, 32'h0000_0055, 1'b1}) begin
      errors++;
      $display("[TB] FAIL timeout_next_op: got err=%b rd=%h data=%h we=%b expected 0/06/00000055/1",
               bus_err_o, rd_addr_o, rd_data_o, rd_we_o);
    end
    drive_idle();
    tick();
  endtask

  // Reset while BUSY drops the request; a late ack after reset is ignored.
  task automatic test_reset_mid_busy();
    logic [110:0] outs;
    rd_addr_i  = 5'd8;
    rd_we_i    = 1'b1;
    mem_addr_i = 32'h0000_0010;
    mem_re_i   = 1'b1;
    opfunc3_i  = 3'b010;
    tick();
    checks++;
    if (dbus_req_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstbusy_req: got %b expected 1", dbus_req_o);
    end
    rst_i = 1'b0;
    tick();
    drive_idle();
    outs = {dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
            rd_addr_o, rd_data_o, rd_we_o, misalign_o, bus_err_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("[TB] FAIL rstbusy_outputs: got %h expected 0", outs);
    end
    rst_i        = 1'b1;
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'h7777_7777;
    tick();
    dbus_ack_i = 1'b0;
    checks++;
    if ({rd_we_o, dbus_req_o, rd_data_o} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL rstbusy_late_ack: got we=%b req=%b data=%h expected 0/0/00000000",
               rd_we_o, dbus_req_o, rd_data_o);
    end
    tick();
  endtask

  initial begin
    drive_idle();
    rst_i        = 1'b0;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'h0;
    test_reset();
    test_passthrough();
    // LB at 0x103: top byte 0x80 sign-extends; ack on the fourth BUSY cycle,
    // which is also the last cycle before the timeout would fire.
    test_load("lb",  32'h0000_0103, 3'b000, 5'd7, 32'h80AA_BBCC, 3, 4'b1000, 32'hFFFF_FF80, 1'b1);
    test_load("lbu", 32'h0000_0103, 3'b100, 5'd7, 32'h80AA_BBCC, 3, 4'b1000, 32'h0000_0080, 1'b1);
    test_load("lh",  32'h0000_0102, 3'b001, 5'd2, 32'h80AA_BBCC, 0, 4'b1100, 32'hFFFF_80AA, 1'b1);
    test_load("lhu", 32'h0000_0200, 3'b101, 5'd2, 32'h1234_F00D, 1, 4'b0011, 32'h0000_F00D, 1'b1);
    test_load("lw",  32'h0000_0044, 3'b010, 5'd1, 32'h89AB_CDEF, 0, 4'b1111, 32'h89AB_CDEF, 1'b1);
    // Load to x0 must not write back.
    test_load("lw_x0", 32'h0000_0048, 3'b010, 5'd0, 32'h5555_AAAA, 0, 4'b1111, 32'h5555_AAAA, 1'b0);
    test_store_half();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; consumes its registered outputs (rd_addr, rd_data, rd_we, mem_addr, mem_re, mem_we, opfunc3).
- Drives a single-outstanding-request data bus with byte enables.
- Sign/zero-extends load data and registers the result toward writeback.
- Stalls upstream while a bus access is in flight.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles without dbus_ack_i before bus error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- rd_addr_i  in  5  destination register from execute
- rd_data_i  in  XLEN  ALU result; store data for stores
- rd_we_i  in  1  register write enable
- mem_addr_i  in  XLEN  effective byte address
- mem_re_i  in  1  load
- mem_we_i  in  1  store
- opfunc3_i  in  3  funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- stall_o  out  1  hold execute outputs (combinational)
- dbus_req_o  out  1  bus request (registered)
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  XLEN  word-aligned address ({mem_addr[31:2],2'b00})
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  XLEN  lane-replicated store data
- dbus_ack_i  in  1  access complete; rdata valid same cycle
- dbus_rdata_i  in  XLEN  read word
- rd_addr_o  out  5  to writeback
- rd_data_o  out  XLEN  to writeback
- rd_we_o  out  1  to writeback
- misalign_o  out  1  one-cycle pulse: misaligned or illegal funct3 access
- bus_err_o  out  1  one-cycle pulse: timeout

Behaviour:
- Reset (rst_i==0 at posedge):
  - All outputs registered low/zero; state=IDLE; timeout counter=0.
  - An in-flight request is abandoned and dbus_req_o drops next cycle.
  - dbus_ack_i is ignored while in IDLE.
- FSM states: IDLE, BUSY.
- IDLE, no memory op (mem_re_i|mem_we_i==0):
  - One-cycle pass-through: rd_*_o <= rd_*_i.
  - stall_o=0.
- IDLE, legal and aligned memory op:
  - stall_o=1.
  - Capture address, be, wdata, we, funct3, rd_addr into request registers.
  - dbus_req_o<=1; next state BUSY.
  - Writeback bubble this cycle (rd_we_o<=0).
- Alignment rules:
  - Half accesses require addr[0]==0; word accesses require addr[1:0]==00.
  - funct3 011/110/111, and store funct3 >010, are illegal.
- Illegal or misaligned op:
  - No bus request; misalign_o<=1 for one cycle; rd_we_o<=0.
  - stall_o=0; stay IDLE.
- BUSY:
  - dbus_req_o and its payload are held stable; stall_o = !dbus_ack_i.
  - On dbus_ack_i: dbus_req_o<=0; state<=IDLE.
  - On ack, load: rd_data_o <= extended lane data; rd_we_o <= captured rd_we (forced 0 if rd_addr==0).
  - On ack, store: rd_we_o<=0.
  - Execute advances on the same edge because stall_o is low.
- Timeout: the counter increments each BUSY cycle without ack. At TIMEOUT_CYCLES:
  - bus_err_o<=1 for one cycle.
  - dbus_req_o<=0; rd_we_o<=0; state<=IDLE; stall_o released that cycle.
- Latency:
  - Non-memory ops: 1 cycle.
  - Memory ops: 1 + N cycles, where N is the number of BUSY cycles up to and including the ack cycle; minimum 2.
- Byte enables:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<addr[1:0].
  - SW: 1111.
- Write data:
  - SB: byte replicated x4.
  - SH: half replicated x2.
  - SW: unchanged.
- Load extraction:
  - Byte: rdata >> (8*addr[1:0]).
  - Half: rdata >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Simultaneous mem_re_i and mem_we_i is treated as illegal and handled as misaligned.
- While BUSY, the held upstream inputs are ignored.

Decomposition:
- Shared package:
  - funct3 load/store constants.
  - FSM state enum {IDLE,BUSY}.
  - XLEN define (existing defines.v).
- Sub-module lsu_align, combinational:
  - Produces be, replicated wdata, misalign flag and extended load data.
  - Inputs: funct3, addr[1:0], store data, rdata.

Test Plan:
- ALU passthrough: rd_addr=5, rd_data=0x1234, rd_we=1, no mem op -> next cycle rd_*_o match; stall_o=0 throughout.
- LB at addr 0x103, ack after 3 BUSY cycles, rdata=0x80AABBCC:
  - stall_o high for 4 cycles.
  - dbus_addr_o=0x100, be=1000.
  - rd_data_o=0xFFFFFF80.
  - LBU of the same access -> 0x00000080.
- SH at addr 0x22, data 0x0000BEEF, ack immediate:
  - be=1100, wdata=0xBEEFBEEF, dbus_we_o=1.
  - rd_we_o=0.
  - 2-cycle latency.
- LW at addr 0x41 -> misalign_o pulse 1 cycle, no dbus_req_o, rd_we_o=0, stall_o=0.
- Timeout with TIMEOUT_CYCLES=4, never ack -> bus_err_o pulses after 4 BUSY cycles; req drops; next ALU op passes through.
- rst_i=0 mid-BUSY:
  - Next cycle dbus_req_o=0, all outputs 0, state IDLE.
  - A late ack after reset releases is ignored (no rd_we_o).
